// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage holding the PC, capturing prog_mem words into an
// instruction register, with stall, branch redirect/flush and HALT detection.
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int INSTR_W = 17,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int OP_MSB = 16,
    parameter int OP_LSB = 12,
    parameter logic [OP_MSB-OP_LSB:0] HALT_OP = 5'h1F
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  pc_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    output logic               halted
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state;
    logic [ADDR_W-1:0] pc;
    logic is_halt;
    assign pc_addr = pc;
    assign halted = (state == HALT);
    assign is_halt = (prog_data[OP_MSB:OP_LSB] == HALT_OP);
    // Branch beats stall; in HALT the PC parks on the HALT word's address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            ir <= '0;
            ir_pc <= '0;
            ir_valid <= 1'b0;
            state <= RUN;
        end else if (br_taken) begin
            pc <= br_target;
            ir_valid <= 1'b0;
            state <= RUN;
        end else if (!stall) begin
            if (state == RUN) begin
                ir <= prog_data;
                ir_pc <= pc;
                ir_valid <= 1'b1;
                state <= is_halt ? HALT : RUN;
                pc <= is_halt ? pc : pc + ADDR_W'(1);
            end else begin
                ir_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a behavioural ROM and hand-computed expectations.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] pc_addr;
    logic [16:0] prog_data;
    logic stall = 1'b0;
    logic br_taken = 1'b0;
    logic [7:0] br_target = 8'h00;
    logic [16:0] ir;
    logic [7:0] ir_pc;
    logic ir_valid;
    logic halted;
    logic [16:0] rom [256];
    int n_checks = 0;
    int n_fails = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .prog_data(prog_data),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
    );

    always #5 clk = ~clk;
    assign prog_data = rom[pc_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic [7:0] e_irpc,
                           input logic [16:0] e_ir, input logic e_v, input logic e_h);
        chk({tag, "_pc"}, 32'(pc_addr), 32'(e_pc));
        chk({tag, "_irpc"}, 32'(ir_pc), 32'(e_irpc));
        chk({tag, "_ir"}, 32'(ir), 32'(e_ir));
        chk({tag, "_valid"}, 32'(ir_valid), 32'(e_v));
        chk({tag, "_halted"}, 32'(halted), 32'(e_h));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {5'(i % 16), 12'(i) ^ 12'hA5A};
        rom[6] = {5'h1F, 12'h123};
        #1 chk_all("reset", 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
        #11 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk_all("seq", 8'(i + 1), 8'(i), rom[i], 1'b1, 1'b0);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_all("stall", 8'h04, 8'h03, rom[3], 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick;
        chk_all("resume", 8'h05, 8'h04, rom[4], 1'b1, 1'b0);
        br_taken = 1'b1; br_target = 8'h40;
        tick;
        chk_all("br_bubble", 8'h40, 8'h04, rom[4], 1'b0, 1'b0);
        br_taken = 1'b0;
        tick;
        chk_all("br_first", 8'h41, 8'h40, rom[8'h40], 1'b1, 1'b0);
        br_taken = 1'b1; br_target = 8'h06;
        tick;
        chk_all("to_halt", 8'h06, 8'h40, rom[8'h40], 1'b0, 1'b0);
        br_taken = 1'b0;
        tick;
        chk_all("halt_word", 8'h06, 8'h06, rom[6], 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick;
            chk_all("halted", 8'h06, 8'h06, rom[6], 1'b0, 1'b1);
        end
        br_taken = 1'b1; br_target = 8'h00;
        tick;
        chk_all("restart", 8'h00, 8'h06, rom[6], 1'b0, 1'b0);
        br_taken = 1'b0;
        tick;
        chk_all("restart_first", 8'h01, 8'h00, rom[0], 1'b1, 1'b0);
        stall = 1'b1; br_taken = 1'b1; br_target = 8'hFF;
        tick;
        chk_all("br_vs_stall", 8'hFF, 8'h00, rom[0], 1'b0, 1'b0);
        stall = 1'b0; br_taken = 1'b0;
        tick;
        chk_all("wrap", 8'h00, 8'hFF, rom[8'hFF], 1'b1, 1'b0);
        stall = 1'b1;
        tick;
        chk_all("pre_rst_stall", 8'h00, 8'hFF, rom[8'hFF], 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1 chk_all("rst_in_stall", 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
        #1 rst = 1'b0; stall = 1'b0;
        br_taken = 1'b1; br_target = 8'h06;
        tick;
        br_taken = 1'b0;
        tick;
        tick;
        chk_all("pre_rst_halt", 8'h06, 8'h06, rom[6], 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 chk_all("rst_in_halt", 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick;
        chk_all("post_rst", 8'h01, 8'h00, rom[0], 1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
